// File: rtl/rng_pkg.sv
// Shared types and constants for the latch TRNG run sequencer.
// Imported by the sequencer top and its word FIFO.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [15:0] STAT_SAT = 16'hFFFF;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/rng_word_fifo.sv
// Small synchronous word buffer between the bit packer and the stream.
// A push while full is accepted only when a pop frees a slot the same cycle.
module rng_word_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rng_sequencer.sv
// Run controller for the latch TRNG: decimates and packs raw bits into
// 32-bit words, buffers them and streams them out over AXI-Stream.
module rng_sequencer
  import rng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W = 16
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic        RNG_GO,
  input  logic        RNG_STOP,
  input  logic [31:0] RNG_SEND_BYTES,
  input  logic [31:0] RNG_DMA_BYTES,
  input  logic [31:0] RNG_PARAMETER,
  input  logic        RAW_BIT,
  input  logic        RAW_VALID,
  output logic        RNG_RUN,
  output logic        RNG_OVER,
  output logic [31:0] RNG_SENT_BYTES,
  output logic [31:0] RNG_STATS,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [STAT_W-1:0] SAT = STAT_W'(STAT_SAT);

  state_t state;
  state_t state_nxt;

  logic [29:0]       send_words;
  logic [29:0]       dma_words;
  logic [7:0]        dec;
  logic [7:0]        dec_cnt;
  logic [31:0]       shreg;
  logic [4:0]        bit_idx;
  logic [STAT_W-1:0] bits;
  logic [STAT_W-1:0] ones;
  logic [29:0]       words_pushed;
  logic [29:0]       pkt_cnt;
  logic              push_pend;
  logic [31:0]       push_word;
  logic              over;
  logic [31:0]       sent;

  logic              go_idle;
  logic              accept;
  logic              word_done;
  logic              budget_hit;
  logic              beat;
  logic              drop;
  logic              pkt_hit;
  logic              drain_last;
  logic              last;

  logic [31:0]       head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     fcount;

  logic              unused_cfg;

  assign unused_cfg = ^{RNG_SEND_BYTES[1:0], RNG_DMA_BYTES[1:0],
                        RNG_PARAMETER[31:8]};

  assign go_idle    = (state == IDLE) & RNG_GO;
  assign accept     = (state == RUN) & RAW_VALID & (dec_cnt == dec);
  assign word_done  = accept & (bit_idx == 5'd31);
  assign budget_hit = word_done & (send_words != '0) &
                      (words_pushed + 30'd1 == send_words);
  assign beat       = ~empty & M_AXIS_TREADY;
  assign drop       = push_pend & full & ~M_AXIS_TREADY;
  assign pkt_hit    = (dma_words != '0) & (pkt_cnt + 30'd1 == dma_words);
  assign drain_last = (state == DRAIN) & (fcount == CW'(1)) & ~push_pend;
  assign last       = pkt_hit | drain_last;

  assign RNG_RUN        = (state != IDLE);
  assign RNG_OVER       = over;
  assign RNG_SENT_BYTES = sent;
  assign RNG_STATS      = {ones, bits};
  assign M_AXIS_TVALID  = ~empty;
  assign M_AXIS_TDATA   = empty ? '0 : head;
  assign M_AXIS_TLAST   = ~empty & last;

  rng_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (AXIS_ACLK),
    .rst   (AXIS_ARESET),
    .push  (push_pend),
    .wdata (push_word),
    .pop   (M_AXIS_TREADY),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  // run state register
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) state <= IDLE;
    else             state <= state_nxt;
  end

  // the word completing the byte budget ends the run in the same cycle,
  // so no further bit is counted while its push is still in flight
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (RNG_GO) state_nxt = RUN;
      RUN:     if (RNG_STOP || budget_hit) state_nxt = DRAIN;
      DRAIN:   if (empty && !push_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // run configuration captured on GO
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      send_words <= '0;
      dma_words  <= '0;
      dec        <= '0;
    end else if (go_idle) begin
      send_words <= RNG_SEND_BYTES[31:2];
      dma_words  <= RNG_DMA_BYTES[31:2];
      dec        <= RNG_PARAMETER[7:0];
    end
  end

  // decimation, bit packing, statistics and word hand-off
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      dec_cnt      <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      bits         <= '0;
      ones         <= '0;
      words_pushed <= '0;
      push_pend    <= 1'b0;
      push_word    <= '0;
    end else begin
      push_pend <= word_done;
      if (go_idle) begin
        dec_cnt      <= '0;
        shreg        <= '0;
        bit_idx      <= '0;
        bits         <= '0;
        ones         <= '0;
        words_pushed <= '0;
      end else begin
        if (state == RUN && RAW_VALID)
          dec_cnt <= accept ? 8'd0 : dec_cnt + 8'd1;
        if (accept) begin
          shreg[bit_idx] <= RAW_BIT;
          bit_idx        <= bit_idx + 5'd1;
          if (bits != SAT) bits <= bits + 1'b1;
          if (RAW_BIT && ones != SAT) ones <= ones + 1'b1;
        end
        if (word_done) begin
          push_word    <= {RAW_BIT, shreg[30:0]};
          words_pushed <= words_pushed + 30'd1;
        end
      end
    end
  end

  // stream-side bookkeeping: sent bytes, packet position, overflow flag
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      sent    <= '0;
      pkt_cnt <= '0;
      over    <= 1'b0;
    end else if (go_idle) begin
      sent    <= '0;
      pkt_cnt <= '0;
      over    <= 1'b0;
    end else begin
      if (drop) over <= 1'b1;
      if (beat) begin
        sent    <= sent + 32'(WORD_BYTES);
        pkt_cnt <= last ? 30'd0 : pkt_cnt + 30'd1;
      end
    end
  end

endmodule

// File: tb/tb_rng_sequencer.sv
// Self-checking bench for rng_sequencer: directed runs plus randomized
// runs compared against a bit-stream reference model.
module tb_rng_sequencer;

  logic        clk = 1'b0;
  logic        areset;
  logic        go;
  logic        stop;
  logic [31:0] send_bytes;
  logic [31:0] dma_bytes;
  logic [31:0] param_w;
  logic        raw_bit;
  logic        raw_valid;
  logic        run;
  logic        over;
  logic [31:0] sent;
  logic [31:0] stats;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] beat_q[$];

  int m_d;
  int m_send_w;
  int m_dma_w;
  int m_vcnt;
  bit m_run;
  bit m_bits[$];
  int m_ones;
  bit rdy_rand;

  rng_sequencer #(
    .FIFO_DEPTH (4),
    .STAT_W     (16)
  ) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESET    (areset),
    .RNG_GO         (go),
    .RNG_STOP       (stop),
    .RNG_SEND_BYTES (send_bytes),
    .RNG_DMA_BYTES  (dma_bytes),
    .RNG_PARAMETER  (param_w),
    .RAW_BIT        (raw_bit),
    .RAW_VALID      (raw_valid),
    .RNG_RUN        (run),
    .RNG_OVER       (over),
    .RNG_SENT_BYTES (sent),
    .RNG_STATS      (stats),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TREADY  (tready),
    .M_AXIS_TLAST   (tlast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!areset && tvalid && tready) beat_q.push_back({tlast, tdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(int d, int sb, int db);
    send_bytes = 32'(sb) | ($urandom & 32'h3);
    dma_bytes  = 32'(db) | ($urandom & 32'h3);
    param_w    = ($urandom & 32'hFFFF_FF00) | 32'(d);
    raw_valid  = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    send_bytes = $urandom;
    dma_bytes  = $urandom;
    param_w    = $urandom;
    m_d = d;
    m_send_w = sb / 4;
    m_dma_w  = db / 4;
    m_vcnt = 0;
    m_run  = 1'b1;
    m_ones = 0;
    m_bits.delete();
    beat_q.delete();
  endtask

  task automatic drive(bit v, bit b);
    raw_valid = v;
    raw_bit   = b;
    if (rdy_rand) tready = ($urandom_range(0, 3) != 0);
    tick();
    if (m_run && v) begin
      m_vcnt++;
      if (m_vcnt % (m_d + 1) == 0) begin
        m_bits.push_back(b);
        m_ones += int'(b);
        if (m_send_w != 0 && m_bits.size() == 32 * m_send_w) m_run = 1'b0;
      end
    end
    raw_valid = 1'b0;
  endtask

  task automatic do_stop();
    raw_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_run = 1'b0;
  endtask

  task automatic wait_idle(string tag, int max);
    for (int i = 0; i < max && run; i++) begin
      if (rdy_rand) tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk({tag, "_idle"}, 32'(run), 32'd0);
  endtask

  function automatic logic [31:0] model_word(int w);
    logic [31:0] ew;
    for (int j = 0; j < 32; j++) ew[j] = m_bits[32 * w + j];
    return ew;
  endfunction

  function automatic logic [31:0] model_stats();
    int nb;
    int no;
    nb = (m_bits.size() > 65535) ? 65535 : m_bits.size();
    no = (m_ones > 65535) ? 65535 : m_ones;
    return {16'(no), 16'(nb)};
  endfunction

  task automatic check_stream(string tag);
    int nw;
    logic exp_last;
    nw = m_bits.size() / 32;
    chk({tag, "_beats"}, 32'(beat_q.size()), 32'(nw));
    for (int w = 0; w < nw && w < beat_q.size(); w++) begin
      exp_last = (m_dma_w != 0 && (w + 1) % m_dma_w == 0) || (w == nw - 1);
      chk($sformatf("%s_data%0d", tag, w), beat_q[w][31:0], model_word(w));
      chk($sformatf("%s_last%0d", tag, w), 32'(beat_q[w][32]), 32'(exp_last));
    end
    chk({tag, "_sent"}, sent, 32'(4 * nw));
    chk({tag, "_stats"}, stats, model_stats());
  endtask

  initial begin
    areset = 1'b1;
    go = 1'b0;
    stop = 1'b0;
    send_bytes = '0;
    dma_bytes = '0;
    param_w = '0;
    raw_bit = 1'b0;
    raw_valid = 1'b0;
    tready = 1'b0;
    rdy_rand = 1'b0;
    tick();
    tick();
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_sent", sent, 32'd0);
    chk("rst_stats", stats, 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    areset = 1'b0;
    tick();

    // alternating bits, two-word budget
    start(0, 8, 0);
    tready = 1'b1;
    chk("t1_run", 32'(run), 32'd1);
    for (int i = 0; i < 64; i++) drive(1'b1, (i % 2) == 0);
    wait_idle("t1", 20);
    check_stream("t1");
    chk("t1_word", beat_q.size() > 0 ? beat_q[0][31:0] : 32'd0, 32'h5555_5555);
    chk("t1_stats_k", stats, 32'h0020_0040);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    chk("t1_idle_ign", stats, 32'h0020_0040);

    // decimation by 4, first-word latency
    start(3, 4, 0);
    for (int i = 0; i < 128; i++) drive(1'b1, 1'b1);
    chk("t2_lat0", 32'(tvalid), 32'd0);
    tick();
    chk("t2_lat1", 32'(tvalid), 32'd1);
    chk("t2_tdata", tdata, 32'hFFFF_FFFF);
    chk("t2_tlast", 32'(tlast), 32'd1);
    wait_idle("t2", 20);
    check_stream("t2");
    chk("t2_stats_k", stats, 32'h0020_0020);

    // packet boundaries every 4 words over a 10-word run
    start(0, 40, 16);
    for (int i = 0; i < 2000 && m_run; i++) drive(1'b1, 1'($urandom));
    wait_idle("t3", 20);
    check_stream("t3");

    // overflow with a stalled sink, then STOP drains the buffer
    start(0, 0, 0);
    tready = 1'b0;
    for (int i = 0; i < 130; i++) drive(1'b1, 1'($urandom));
    chk("t4_over_pre", 32'(over), 32'd0);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'($urandom));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    chk("t4_over", 32'(over), 32'd1);
    chk("t4_stats", stats, model_stats());
    do_stop();
    tready = 1'b1;
    wait_idle("t4", 20);
    chk("t4_beats", 32'(beat_q.size()), 32'd4);
    for (int w = 0; w < 4 && w < beat_q.size(); w++) begin
      chk($sformatf("t4_data%0d", w), beat_q[w][31:0], model_word(w));
      chk($sformatf("t4_last%0d", w), 32'(beat_q[w][32]), 32'(w == 3));
    end
    chk("t4_sent", sent, 32'd16);
    chk("t4_over_hold", 32'(over), 32'd1);

    // STOP with a partial word; GO clears statistics and overflow
    start(0, 0, 0);
    chk("t5_over_clr", 32'(over), 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom));
    chk("t5_stats", stats, model_stats());
    do_stop();
    tick();
    chk("t5_run", 32'(run), 32'd0);
    chk("t5_beats", 32'(beat_q.size()), 32'd0);
    chk("t5_stats_hold", stats, model_stats());
    start(0, 0, 0);
    chk("t5_stats_clr", stats, 32'd0);
    chk("t5_sent_clr", sent, 32'd0);
    do_stop();
    tick();
    chk("t5_run2", 32'(run), 32'd0);

    // reset in the middle of a run with queued words
    start(0, 0, 0);
    tready = 1'b1;
    for (int i = 0; i < 32; i++) drive(1'b1, 1'($urandom));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    chk("t6_sent_pre", sent, 32'd4);
    tready = 1'b0;
    for (int i = 0; i < 64; i++) drive(1'b1, 1'($urandom));
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0);
    chk("t6_tvalid_pre", 32'(tvalid), 32'd1);
    areset = 1'b1;
    tick();
    chk("t6_tvalid", 32'(tvalid), 32'd0);
    chk("t6_run", 32'(run), 32'd0);
    chk("t6_sent", sent, 32'd0);
    chk("t6_stats", stats, 32'd0);
    areset = 1'b0;
    tick();

    // randomized runs against the bit-stream model
    rdy_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int d;
      int sw;
      int dw;
      d  = $urandom_range(0, 3);
      sw = $urandom_range(1, 6);
      dw = $urandom_range(0, 3);
      start(d, 4 * sw, 4 * dw);
      for (int i = 0; i < 6000 && m_run; i++)
        drive($urandom_range(0, 3) != 0, 1'($urandom));
      wait_idle($sformatf("r%0d", k), 400);
      check_stream($sformatf("r%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
